// File: rtl/smoothing_scheduler_if.sv
// Request/result bundle between tracker channels, the smoothing scheduler and its consumer.
// master = requesters + result consumer; slave = the scheduler.
// Combinational wiring only; the scheduler's outputs are all registered.
interface smoothing_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int W      = 10
);
  localparam int CW = $clog2(NUM_CH);

  logic                clear;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH*W-1:0] x_in;
  logic [NUM_CH*W-1:0] y_in;
  logic [NUM_CH-1:0]   ack;
  logic                out_valid;
  logic                out_ready;
  logic [CW-1:0]       out_chan;
  logic [W-1:0]        smoothedX;
  logic [W-1:0]        smoothedY;
  logic                dropped;
  logic                busy;

  modport master (
    output clear, req, x_in, y_in, out_ready,
    input  ack, out_valid, out_chan, smoothedX, smoothedY, dropped, busy
  );

  modport slave (
    input  clear, req, x_in, y_in, out_ready,
    output ack, out_valid, out_chan, smoothedX, smoothedY, dropped, busy
  );
endinterface

// File: rtl/smoothing_scheduler.sv
// Round-robin shares one 4-tap x/y moving-average datapath across NUM_CH tracked points.
// Latency: req seen in IDLE at cycle 0 -> ack at cycle 1 -> out_valid at cycle 3 (4-cycle throughput).
// Backpressure: result held in OUT until out_ready; no new grant is issued while waiting.
module smoothing_scheduler #(
  parameter int NUM_CH = 4,
  parameter int W      = 10
) (
  input logic                  clk,
  input logic                  reset,
  smoothing_scheduler_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int SW = W + 2;

  typedef enum logic [1:0] {IDLE, CAPTURE, SUM, OUT} state_t;

  state_t            state_q;
  logic [CW-1:0]     rr_q;
  logic [CW-1:0]     gnt_q;
  logic [NUM_CH-1:0] primed_q;
  logic [NUM_CH-1:0] ack_q;
  logic              out_valid_q;
  logic              dropped_q;
  logic              busy_q;
  logic [CW-1:0]     out_chan_q;
  logic [W-1:0]      sx_q;
  logic [W-1:0]      sy_q;
  // Per-channel history, entry 0 is the newest sample.
  logic [W-1:0]      hx_q [NUM_CH][4];
  logic [W-1:0]      hy_q [NUM_CH][4];

  logic [W-1:0]      xin_a [NUM_CH];
  logic [W-1:0]      yin_a [NUM_CH];
  logic [CW:0]       cand_d;
  logic [CW-1:0]     gnt_d;
  logic              gnt_vld_d;
  logic [CW-1:0]     rr_next_d;
  logic [W-1:0]      cap_x_d;
  logic [W-1:0]      cap_y_d;
  logic              x_same_d;
  logic              y_same_d;
  logic [SW-1:0]     sum_x_d;
  logic [SW-1:0]     sum_y_d;

  // Unpack the flat per-channel coordinate buses.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign xin_a[c] = bus.x_in[c*W +: W];
    assign yin_a[c] = bus.y_in[c*W +: W];
  end

  // Round-robin pick: first requesting channel at or after rr_q, wrapping.
  // Scanning downwards lets the smallest offset win without a break.
  always_comb begin
    cand_d    = '0;
    gnt_d     = '0;
    gnt_vld_d = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand_d = {1'b0, rr_q} + (CW+1)'(i);
      if (cand_d >= (CW+1)'(NUM_CH)) begin
        cand_d = cand_d - (CW+1)'(NUM_CH);
      end
      if (bus.req[cand_d[CW-1:0]]) begin
        gnt_d     = cand_d[CW-1:0];
        gnt_vld_d = 1'b1;
      end
    end
  end

  assign rr_next_d = (gnt_q == CW'(NUM_CH - 1)) ? '0 : gnt_q + CW'(1);
  assign cap_x_d   = xin_a[gnt_q];
  assign cap_y_d   = yin_a[gnt_q];
  assign x_same_d  = (cap_x_d == hx_q[gnt_q][0]);
  assign y_same_d  = (cap_y_d == hy_q[gnt_q][0]);

  // Sums are W+2 bits wide so four full-scale entries never overflow.
  assign sum_x_d = SW'(hx_q[gnt_q][0]) + SW'(hx_q[gnt_q][1])
                 + SW'(hx_q[gnt_q][2]) + SW'(hx_q[gnt_q][3]);
  assign sum_y_d = SW'(hy_q[gnt_q][0]) + SW'(hy_q[gnt_q][1])
                 + SW'(hy_q[gnt_q][2]) + SW'(hy_q[gnt_q][3]);

  // Control FSM with registered outputs; history and priming updates happen in CAPTURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      primed_q    <= '0;
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_chan_q  <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 4; k++) begin
          hx_q[c][k] <= '0;
          hy_q[c][k] <= '0;
        end
      end
    end else begin
      ack_q     <= '0;
      dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clear) begin
            primed_q <= '0;
          end else if (gnt_vld_d) begin
            gnt_q   <= gnt_d;
            ack_q   <= NUM_CH'(1) << gnt_d;
            busy_q  <= 1'b1;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          rr_q <= rr_next_d;
          if (!primed_q[gnt_q]) begin
            // First sample after reset/clear fills the whole window so the
            // average starts at the sample itself rather than ramping from 0.
            for (int k = 0; k < 4; k++) begin
              hx_q[gnt_q][k] <= cap_x_d;
              hy_q[gnt_q][k] <= cap_y_d;
            end
            primed_q[gnt_q] <= 1'b1;
            state_q         <= SUM;
          end else begin
            if (!x_same_d) begin
              for (int k = 3; k > 0; k--) begin
                hx_q[gnt_q][k] <= hx_q[gnt_q][k-1];
              end
              hx_q[gnt_q][0] <= cap_x_d;
            end
            if (!y_same_d) begin
              for (int k = 3; k > 0; k--) begin
                hy_q[gnt_q][k] <= hy_q[gnt_q][k-1];
              end
              hy_q[gnt_q][0] <= cap_y_d;
            end
            if (x_same_d && y_same_d) begin
              dropped_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q <= SUM;
            end
          end
        end
        SUM: begin
          sx_q        <= W'(sum_x_d >> 2);
          sy_q        <= W'(sum_y_d >> 2);
          out_chan_q  <= gnt_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.smoothedX = sx_q;
  assign bus.smoothedY = sy_q;
  assign bus.dropped   = dropped_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_smoothing_scheduler.sv
// Bench for smoothing_scheduler: directed scenarios with literal expectations, then random traffic.
// A transaction-level model (cycle stamps, per-channel sample windows) predicts every output.
// Inputs driven 1 time unit after posedge; outputs compared on every negedge.
module tb_smoothing_scheduler;
  localparam int NUM_CH = 4;
  localparam int W      = 10;
  localparam int INF    = 1 << 30;

  logic clk = 1'b0;
  logic reset;

  smoothing_scheduler_if #(.NUM_CH(NUM_CH), .W(W)) bus ();
  smoothing_scheduler #(.NUM_CH(NUM_CH), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vec_cnt++;
    if (act !== want) begin
      miss_cnt++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, want);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int cyc = 0, idle_at = 0, cap_cyc = -1, out_at = -1;
  int rr = 0, g = 0, og = 0, p_sx = 0, p_sy = 0;
  bit primed [NUM_CH];
  int hx [NUM_CH][4];
  int hy [NUM_CH][4];
  logic [NUM_CH-1:0] e_ack = '0, m_prev_ack = '0;
  bit e_valid = 0, e_drop = 0, e_busy = 0;
  int e_chan = 0, e_sx = 0, e_sy = 0;

  always @(posedge clk) begin
    int p, x, y;
    bit dx, dy;
    p = cyc;
    cyc = cyc + 1;
    m_prev_ack = e_ack;
    if (!reset) begin
      e_ack = '0; e_valid = 0; e_drop = 0; e_busy = 0;
      idle_at = cyc; cap_cyc = -1; out_at = -1; rr = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        primed[c] = 0;
        for (int k = 0; k < 4; k++) begin hx[c][k] = 0; hy[c][k] = 0; end
      end
    end else begin
      e_ack = '0;
      e_drop = 0;
      if (e_valid && bus.out_ready) begin
        e_valid = 0;
        idle_at = cyc;
      end
      if (p == cap_cyc) begin
        x = int'(bus.x_in[g*W +: W]);
        y = int'(bus.y_in[g*W +: W]);
        rr = (g + 1) % NUM_CH;
        dx = 1; dy = 1;
        if (!primed[g]) begin
          for (int k = 0; k < 4; k++) begin hx[g][k] = x; hy[g][k] = y; end
          primed[g] = 1;
        end else begin
          dx = (x != hx[g][0]);
          dy = (y != hy[g][0]);
          if (dx) begin for (int k = 3; k > 0; k--) hx[g][k] = hx[g][k-1]; hx[g][0] = x; end
          if (dy) begin for (int k = 3; k > 0; k--) hy[g][k] = hy[g][k-1]; hy[g][0] = y; end
        end
        if (!dx && !dy) begin
          e_drop = 1;
          idle_at = cyc;
        end else begin
          out_at = cyc + 1;
          og = g;
          p_sx = (hx[g][0] + hx[g][1] + hx[g][2] + hx[g][3]) / 4;
          p_sy = (hy[g][0] + hy[g][1] + hy[g][2] + hy[g][3]) / 4;
        end
      end
      if (cyc == out_at) begin
        e_valid = 1; e_chan = og; e_sx = p_sx; e_sy = p_sy;
      end
      if (p >= idle_at) begin
        if (bus.clear) begin
          for (int c = 0; c < NUM_CH; c++) primed[c] = 0;
        end else if (bus.req != '0) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (bus.req[(rr + i) % NUM_CH]) begin g = (rr + i) % NUM_CH; break; end
          end
          e_ack[g] = 1'b1;
          cap_cyc = cyc;
          idle_at = INF;
        end
      end
      e_busy = (cyc < idle_at);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ack", 32'(bus.ack), 32'(0));
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_dropped", 32'(bus.dropped), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_out_chan", 32'(bus.out_chan), 32'(0));
      chk("rst_smoothedX", 32'(bus.smoothedX), 32'(0));
      chk("rst_smoothedY", 32'(bus.smoothedY), 32'(0));
    end else begin
      chk("ack", 32'(bus.ack), 32'(e_ack));
      chk("dropped", 32'(bus.dropped), 32'(e_drop));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      if (e_valid) begin
        chk("out_chan", 32'(bus.out_chan), e_chan);
        chk("smoothedX", 32'(bus.smoothedX), e_sx);
        chk("smoothedY", 32'(bus.smoothedY), e_sy);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ch(input int c, input int x, input int y);
    bus.x_in[c*W +: W] = W'(x);
    bus.y_in[c*W +: W] = W'(y);
  endtask

  task automatic send(input int c, input int x, input int y);
    @(posedge clk); #1;
    set_ch(c, x, y);
    bus.req[c] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (m_prev_ack[c]) break;
    end
    bus.req[c] = 1'b0;
  endtask

  task automatic expect_out(input string nm, input int c, input int sx, input int sy);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk({nm, "_seen"}, 32'(seen), 32'(1));
    if (seen) begin
      chk({nm, "_chan"}, 32'(bus.out_chan), c);
      chk({nm, "_x"}, 32'(bus.smoothedX), sx);
      chk({nm, "_y"}, 32'(bus.smoothedY), sy);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req = '0;
    bus.clear = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic new_data(input int c);
    int mode;
    mode = $urandom_range(0, 3);
    if (mode == 1 || mode == 3) bus.x_in[c*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    if (mode == 2 || mode == 3) bus.y_in[c*W +: W] = W'($urandom_range(0, (1 << W) - 1));
  endtask

  // ---------------- main sequence ----------------
  logic [NUM_CH-1:0] got [$];
  logic [NUM_CH-1:0] rr_exp [7];

  initial begin
    int nack, dat;
    reset = 1'b0;
    bus.clear = 1'b0;
    bus.req = '0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Prime with exact latency: req at cycle 0, ack at 1, out_valid at 3.
    #1;
    set_ch(0, 100, 200);
    bus.req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_ack", 32'(bus.ack), 32'(4'b0001));
    @(posedge clk); #1;
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("lat_c2_valid", 32'(bus.out_valid), 32'(0));
    @(negedge clk);
    chk("lat_c3_valid", 32'(bus.out_valid), 32'(1));
    chk("prime_chan", 32'(bus.out_chan), 32'(0));
    chk("prime_x", 32'(bus.smoothedX), 32'(100));
    chk("prime_y", 32'(bus.smoothedY), 32'(200));

    // Averaging.
    send(0, 104, 201); expect_out("avg1", 0, 101, 200);
    send(0, 108, 202); expect_out("avg2", 0, 103, 200);
    send(0, 112, 203); expect_out("avg3", 0, 106, 201);

    // Full duplicate is dropped; x-only change shifts only x.
    send(0, 112, 203);
    @(negedge clk);
    chk("dup_dropped", 32'(bus.dropped), 32'(1));
    chk("dup_no_valid", 32'(bus.out_valid), 32'(0));
    send(0, 116, 203); expect_out("xonly", 0, 110, 201);

    // Round robin from a fresh reset: 0,1,2,3,0 then req=1010 -> 1,3.
    do_reset();
    @(posedge clk); #1;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 500 + c, 600 + c);
    bus.req = '1;
    nack = 0;
    dat = 700;
    for (int i = 0; i < 100 && nack < 7; i++) begin
      @(negedge clk);
      if (bus.ack != '0) got.push_back(bus.ack);
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_prev_ack[c]) begin
          nack++;
          if (nack < 5) begin
            set_ch(c, dat, dat + 1);
            dat += 3;
          end else if (nack == 5) begin
            bus.req = 4'b1010;
            set_ch(1, dat, dat + 5);
            set_ch(3, dat + 7, dat + 9);
            dat += 20;
          end else begin
            bus.req[c] = 1'b0;
          end
        end
      end
    end
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    chk("rr_count", got.size(), 7);
    for (int k = 0; k < 7 && k < got.size(); k++) chk($sformatf("rr_order%0d", k), 32'(got[k]), 32'(rr_exp[k]));

    // Clear in IDLE, then reprime ch0 under backpressure with ch1 waiting.
    repeat (6) @(posedge clk);
    #1 bus.clear = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    send(0, 300, 50);
    set_ch(1, 111, 222);
    bus.req[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_x", 32'(bus.smoothedX), 32'(300));
      chk("bp_y", 32'(bus.smoothedY), 32'(50));
      chk("bp_no_ack", 32'(bus.ack), 32'(0));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ack", 32'(bus.ack), 32'(0));
    chk("bp_idle_valid", 32'(bus.out_valid), 32'(0));
    @(negedge clk);
    chk("bp_ch1_ack", 32'(bus.ack), 32'(4'b0010));
    @(posedge clk); #1;
    bus.req[1] = 1'b0;
    expect_out("bp_ch1", 1, 111, 222);

    // Reset while holding a result: outputs drop at once, next sample reprimes.
    bus.out_ready = 1'b0;
    send(2, 7, 9);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'(1));
    #1 reset = 1'b0;
    #1;
    chk("rst_imm_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_imm_ack", 32'(bus.ack), 32'(0));
    chk("rst_imm_busy", 32'(bus.busy), 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    send(2, 20, 30); expect_out("reprime", 2, 20, 30);

    // Random traffic against the model.
    for (int cy = 0; cy < 3000; cy++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.clear = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_prev_ack[c]) begin
          if ($urandom_range(0, 2) == 0) bus.req[c] = 1'b0;
          else new_data(c);
        end else if (!bus.req[c] && $urandom_range(0, 3) == 0) begin
          bus.req[c] = 1'b1;
          new_data(c);
        end
      end
    end
    bus.req = '0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #1000000;
    miss_cnt++;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $fatal(1, "watchdog");
  end
endmodule
